// File: rtl/tx_arbiter_pkg.sv
// Shared definitions for the transmitter arbiter: FSM encoding, source count and indices,
// and the round-robin pointer advance helper.
package tx_arbiter_pkg;

    localparam int N_SRC     = 3;
    localparam int SRC_KEY   = 0;
    localparam int SRC_WORD  = 1;
    localparam int SRC_TWEET = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

    // Pointer moves to the source just after the winner, wrapping at N_SRC.
    function automatic logic [1:0] next_ptr(input logic [N_SRC-1:0] winner);
        logic [1:0] p;
        p = 2'd0;
        if (winner[SRC_KEY])  p = 2'd1;
        if (winner[SRC_WORD]) p = 2'd2;
        if (winner[SRC_TWEET]) p = 2'd0;
        return p;
    endfunction

endpackage

// File: rtl/tx_arbiter_if.sv
// Source-side and transmitter-side signals of the arbiter. With ARB_STATS_EN defined the
// per-source grant counters are added.
interface tx_arbiter_if
`ifdef ARB_STATS_EN
    #(parameter int STAT_W = 8)
`endif
    ;
    logic [2:0] en;
    logic [2:0] req_start;
    logic [7:0] req_data0;
    logic [7:0] req_data1;
    logic [7:0] req_data2;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [2:0] grant;
    logic [2:0] pending;
    logic [2:0] drop;
    logic       timeout_err;
`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] grant_cnt0;
    logic [STAT_W-1:0] grant_cnt1;
    logic [STAT_W-1:0] grant_cnt2;

    modport master (
        input  en, req_start, req_data0, req_data1, req_data2, tx_busy,
        output tx_data, tx_start, grant, pending, drop, timeout_err,
        output grant_cnt0, grant_cnt1, grant_cnt2
    );
    modport slave (
        output en, req_start, req_data0, req_data1, req_data2, tx_busy,
        input  tx_data, tx_start, grant, pending, drop, timeout_err,
        input  grant_cnt0, grant_cnt1, grant_cnt2
    );
`else
    modport master (
        input  en, req_start, req_data0, req_data1, req_data2, tx_busy,
        output tx_data, tx_start, grant, pending, drop, timeout_err
    );
    modport slave (
        output en, req_start, req_data0, req_data1, req_data2, tx_busy,
        input  tx_data, tx_start, grant, pending, drop, timeout_err
    );
`endif
endinterface

// File: rtl/tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting source at or above ptr, wrapping.
module rr_pick
    import tx_arbiter_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [1:0]       ptr,
    output logic [N_SRC-1:0] gnt,
    output logic             any
);

    always_comb begin
        logic [1:0] idx;
        gnt = '0;
        idx = 2'd0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = 2'((int'(ptr) + k) % N_SRC);
            if (gnt == '0 && req[idx]) begin
                gnt[idx] = 1'b1;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one byte-serial transmitter between three sources, with
// per-source holding registers and a launch timeout. ARB_STATS_EN adds grant counters.
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 16
`ifdef ARB_STATS_EN
    ,
    parameter int STAT_W = 8
`endif
) (
    input  logic         sysclk,
    input  logic         reset,
    tx_arbiter_if.master bus
);

    localparam int TMR_W = $clog2(BUSY_TIMEOUT);

    arb_state_e       state_q, state_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] drop_q, drop_d;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic [N_SRC-1:0] winner_q, winner_d;
    logic [7:0]       hold_q [N_SRC];
    logic [7:0]       hold_d [N_SRC];
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_start_q, tx_start_d;
    logic             timeout_q, timeout_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [1:0]       rr_q, rr_d;

    logic [7:0]       req_data [N_SRC];
    logic [N_SRC-1:0] pick_gnt;
    logic [N_SRC-1:0] consume;
    logic             pick_any;

    assign req_data[SRC_KEY]   = bus.req_data0;
    assign req_data[SRC_WORD]  = bus.req_data1;
    assign req_data[SRC_TWEET] = bus.req_data2;

    rr_pick u_pick (
        .req (pending_q & bus.en),
        .ptr (rr_q),
        .gnt (pick_gnt),
        .any (pick_any)
    );

    assign consume = (state_q == LAUNCH) ? winner_q : '0;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        hold_d     = hold_q;
        drop_d     = '0;
        grant_d    = grant_q;
        winner_d   = winner_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        timeout_d  = 1'b0;
        timer_d    = timer_q;
        rr_d       = rr_q;

        // A byte arriving while its predecessor is being launched refills the slot.
        for (int i = 0; i < N_SRC; i++) begin
            if (!bus.en[i]) begin
                pending_d[i] = 1'b0;
            end else if (bus.req_start[i]) begin
                if (!pending_q[i] || consume[i]) begin
                    hold_d[i]    = req_data[i];
                    pending_d[i] = 1'b1;
                end else begin
                    drop_d[i] = 1'b1;
                end
            end else if (consume[i]) begin
                pending_d[i] = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    winner_d = pick_gnt;
                    state_d  = LAUNCH;
                end
            end
            LAUNCH: begin
                for (int i = 0; i < N_SRC; i++) begin
                    if (winner_q[i]) tx_data_d = hold_q[i];
                end
                tx_start_d = 1'b1;
                grant_d    = winner_q;
                timer_d    = '0;
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TMR_W'(BUSY_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    grant_d   = '0;
                    rr_d      = next_ptr(winner_q);
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    grant_d = '0;
                    rr_d    = next_ptr(winner_q);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            drop_q     <= '0;
            grant_q    <= '0;
            winner_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            timeout_q  <= 1'b0;
            timer_q    <= '0;
            rr_q       <= 2'd0;
            for (int i = 0; i < N_SRC; i++) hold_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            drop_q     <= drop_d;
            grant_q    <= grant_d;
            winner_q   <= winner_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            timeout_q  <= timeout_d;
            timer_q    <= timer_d;
            rr_q       <= rr_d;
            for (int i = 0; i < N_SRC; i++) hold_q[i] <= hold_d[i];
        end
    end

    assign bus.tx_data     = tx_data_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.grant       = grant_q;
    assign bus.pending     = pending_q;
    assign bus.drop        = drop_q;
    assign bus.timeout_err = timeout_q;

`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] cnt_q [N_SRC];
    logic [STAT_W-1:0] cnt_d [N_SRC];

    // Only completed transfers count; a timeout leaves the counters alone.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == WAIT_DONE && !bus.tx_busy) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (winner_q[i]) cnt_d[i] = cnt_q[i] + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_SRC; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.grant_cnt0 = cnt_q[SRC_KEY];
    assign bus.grant_cnt1 = cnt_q[SRC_WORD];
    assign bus.grant_cnt2 = cnt_q[SRC_TWEET];
`endif

endmodule
